uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver for the Nexys4 designs.
//  - Oversampled, majority-vote bit recovery; configurable data width, parity and stop bits.
//  - Received words are buffered in a small FWFT FIFO with valid/ready handshake and per-word error flags.
//  - Sits between the board RX pin and any byte consumer (LED display, command decoder, loopback TX).
// PARAMETERS
//  TICK_DIV    68  sys_clk cycles per oversample tick (125 MHz / 115200 / 16), >=2
//  OVERSAMPLE  16  ticks per bit period; even, >=8
//  DATA_BITS   8   data bits per frame, 5..9, LSB first
//  PARITY      0   0 = none, 1 = odd, 2 = even
//  STOP_BITS   1   1 or 2
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
//  sys_clk     in   1          system clock (125 MHz)
//  rst_n       in   1          asynchronous active-low reset
//  rx          in   1          serial input, idle high, asynchronous to sys_clk
//  rx_data     out  DATA_BITS  FIFO head data word
//  rx_valid    out  1          FIFO non-empty; head word present on rx_data and flags
//  rx_ready    in   1          consumer accept; pop when rx_valid && rx_ready
//  parity_err  out  1          head word failed parity check (0 when PARITY=0)
//  frame_err   out  1          head word had a stop bit sampled low
//  overrun     out  1          one-cycle pulse: completed word dropped because FIFO full
//  busy        out  1          receiver FSM not in IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert inside block)
//  - All outputs 0; FIFO empty; FSM IDLE; rx synchroniser regs = 1.
//  Input and timing
//  - rx passes through a 2-flop synchroniser (rx_s).
//  - Falling-edge detect on rx_s (prev 1, now 0).
//  - Tick counter runs 0..TICK_DIV-1; tick pulses on the terminal count.
//  - Tick counter and bit-tick counter restart on start detection, so bit phase is aligned to the edge.
//  - Sample point: majority of 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//  - IDLE: falling edge -> START, busy=1.
//  - START: voted 1 -> false start, back to IDLE (no push). Voted 0 -> DATA at end of bit period.
//  - DATA: DATA_BITS bits shifted in LSB first. Then PARITY if PARITY!=0, else STOP.
//  - PARITY: err = (^data ^ pbit) != (PARITY==1). Odd parity requires the total count of ones to be odd.
//  - STOP: STOP_BITS bits voted; any 0 sets frame_err.
//  - On the last stop-bit vote, push {parity_err, frame_err, data}, then go to IDLE immediately. The
//    remaining half stop bit is not waited out, so back-to-back frames are received.
//  - Break / stuck-low: frame pushed with frame_err=1. A new frame needs rx_s to return high, then fall.
//  FIFO (first-word-fall-through)
//  - Push latency: rx_valid rises 1 cycle after the push cycle.
//  - Pop when rx_valid && rx_ready. Next head appears the following cycle; rx_valid falls if empty.
//  - Full + push + no pop: word dropped, overrun=1 for 1 cycle, contents unchanged.
//  - Full + push + pop in same cycle: both performed, no overrun.
//  - Empty: rx_ready ignored; rx_data/flags hold the last value, no underflow.
//  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural. full = MSBs differ and LSBs equal.
//  - rst_n low mid-frame: frame discarded, FIFO flushed, FSM IDLE; no push on exit from reset.
// TESTING  (bench: TICK_DIV=4, OVERSAMPLE=16 -> 64 clk/bit unless stated)
//  1. 8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid for 1 cycle, parity_err=0, frame_err=0.
//  2. PARITY=2, send 0xA5 with parity bit 1 -> parity_err=1; repeat with parity bit 0 -> parity_err=0.
//  3. Send 0x3C with stop bit 0, then 20 bit-times low -> exactly one word 0x3C, frame_err=1,
//     no further pushes until rx high then falls.
//  4. Low glitch of 8 clk (2 ticks) -> no push, busy returns 0 within 1 bit time.
//  5. rx_ready=0, send 0x01..0x05 back-to-back -> overrun pulse on 5th; then rx_ready=1 pops 0x01..0x04 only.
//  6. Assert rst_n low mid-DATA of 0x55, release, send 0x77 -> only 0x77 received.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle between uart_rx_param and its word consumer.
// Latency: none (wires only).
// Backpressure: consumer drives rx_ready; a word leaves the producer when rx_valid && rx_ready.
// master = receiver (drives word, flags, status), slave = consumer (drives rx_ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver (3-sample majority vote) feeding a first-word-fall-through output FIFO.
// Latency: word shows on rx_valid 1 cycle after the last stop-bit vote.
// Backpressure: rx_ready pops the FIFO; a word completed while full (and not popping) is dropped, overrun pulses.
// Ports: sys_clk; rst_n (async active-low); rx (serial in, idle high, async);
//        rx_if.master: rx_data/rx_valid/rx_ready head word, parity_err/frame_err head flags, overrun, busy.
module uart_rx_param #(
  parameter int TICK_DIV   = 68,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             rx,
  uart_rx_param_if.master  rx_if
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WW  = DATA_BITS + 2;
  localparam int TCW = $clog2(TICK_DIV);
  localparam int OCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [OCW-1:0] BIT_LAST  = OCW'(OVERSAMPLE - 1);
  localparam logic [OCW-1:0] SAMP_A    = OCW'(OVERSAMPLE / 2 - 1);
  localparam logic [OCW-1:0] SAMP_B    = OCW'(OVERSAMPLE / 2);
  localparam logic [OCW-1:0] SAMP_C    = OCW'(OVERSAMPLE / 2 + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Reset: asserts asynchronously, releases on a clock edge.
  logic rst_meta_q, rst_int_n;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_int_n  <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_int_n  <= rst_meta_q;
    end
  end

  logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [OCW-1:0]       bit_tick_q, bit_tick_d;
  logic [1:0]           samp_q, samp_d;
  state_t               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 busy_q, busy_d, overrun_q, overrun_d;
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [WW-1:0]        head_q, head_d;
  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [WW-1:0]        mem_d [FIFO_DEPTH];

  logic          tick, bit_end, vote_now, vote, fall;
  logic          push, push_ok, pop, empty, full;
  logic [WW-1:0] push_word;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    fall      = rx_prev_q && !rx_s_q;

    tick     = (tick_cnt_q == TICK_LAST);
    bit_end  = tick && (bit_tick_q == BIT_LAST);
    vote_now = tick && (bit_tick_q == SAMP_C);
    // Third sample is taken live on the vote tick.
    vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    bit_tick_d = bit_end ? '0 : (tick ? bit_tick_q + 1'b1 : bit_tick_q);
    samp_d     = samp_q;
    if (tick && bit_tick_q == SAMP_A) samp_d[0] = rx_s_q;
    if (tick && bit_tick_q == SAMP_B) samp_d[1] = rx_s_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    push_word  = {perr_q, ferr_q | ~vote, shreg_q};

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          // Realign bit phase to the start edge.
          state_d    = S_START;
          tick_cnt_d = '0;
          bit_tick_d = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (vote_now && vote) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (vote_now) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (vote_now) perr_d = ((^shreg_q) ^ vote) != (PARITY == 1);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (vote_now) begin
          if (!vote) ferr_d = 1'b1;
          // Leave on the vote so a back-to-back start edge is not missed.
          if (stop_cnt_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);

    empty     = (wr_q == rd_q);
    full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop       = !empty && rx_if.rx_ready;
    push_ok   = push && (!full || pop);
    overrun_d = push && full && !pop;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = push_word;
    wr_d = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    // Head register keeps the last word once the FIFO drains.
    head_d = (wr_d != rd_d) ? mem_d[rd_d[AW-1:0]] : head_q;
  end

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      bit_tick_q <= '0;
      samp_q     <= 2'b11;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      head_q     <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      tick_cnt_q <= tick_cnt_d;
      bit_tick_q <= bit_tick_d;
      samp_q     <= samp_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      head_q     <= head_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  assign rx_if.rx_data    = head_q[DATA_BITS-1:0];
  assign rx_if.frame_err  = head_q[DATA_BITS];
  assign rx_if.parity_err = head_q[DATA_BITS+1];
  assign rx_if.rx_valid   = !empty;
  assign rx_if.overrun    = overrun_q;
  assign rx_if.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int BIT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_a, rx_p;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifp ();

  uart_rx_param #(.TICK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .sys_clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_if(ifa));

  uart_rx_param #(.TICK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .sys_clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_if(ifp));

  int checks = 0;
  int failures = 0;
  int pops_a = 0, vcyc = 0, ovr_a = 0, ovr_p = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_p[$];

  typedef struct {
    bit         sel;     // 0 = 8N1 instance, 1 = even-parity instance
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx_a = b;
  endtask

  // Drives up to max_bits bits of one frame: start, 8 data LSB first, optional parity, stop.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop, input int max_bits);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (has_par) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = stop;
    n++;
    for (int i = 0; i < n && i < max_bits; i++) begin
      drive(sel, bits[i]);
      tick_n(BIT);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_p.size() != 0) && n < 4 * BIT) begin
      tick_n(1);
      n++;
    end
    check(nm, q_a.size() + q_p.size(), 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (ifa.overrun) ovr_a++;
      if (ifp.overrun) ovr_p++;
      if (ifa.rx_valid) begin
        vcyc++;
        if (ifa.rx_ready) begin
          pops_a++;
          if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word_a actual=%0h required=none",
                     {ifa.parity_err, ifa.frame_err, ifa.rx_data});
          end else begin
            check("word_a", {ifa.parity_err, ifa.frame_err, ifa.rx_data}, q_a.pop_front());
          end
        end
      end
      if (ifp.rx_valid) begin
        vcyc++;
        if (ifp.rx_ready) begin
          if (q_p.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word_p actual=%0h required=none",
                     {ifp.parity_err, ifp.frame_err, ifp.rx_data});
          end else begin
            check("word_p", {ifp.parity_err, ifp.frame_err, ifp.rx_data}, q_p.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    int v0, p0, o0;

    // sel, data, parity bit, stop bit, expected parity_err, expected frame_err
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_p = 1'b1;
    ifa.rx_ready = 1'b1;
    ifp.rx_ready = 1'b1;
    tick_n(5);
    check("rst_valid", ifa.rx_valid, 0);
    check("rst_data", ifa.rx_data, 0);
    check("rst_flags", {ifa.parity_err, ifa.frame_err, ifa.overrun, ifa.busy}, 0);
    rst_n = 1'b1;
    tick_n(10);
    check("post_rst_idle", {ifa.rx_valid, ifa.busy, ifp.rx_valid, ifp.busy}, 0);
    fork
      monitor();
    join_none

    // Table: single frames with an idle bit after each, consumer always ready.
    for (int i = 0; i < 9; i++) begin
      v0 = vcyc;
      if (vecs[i].sel) q_p.push_back({vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].d});
      else             q_a.push_back({vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].d});
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].sel, vecs[i].pbit, vecs[i].stop, 99);
      drive(vecs[i].sel, 1'b1);
      tick_n(BIT);
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_valid_cycles", i), vcyc - v0, 1);
    end

    // Break: stop bit low then 20 bit-times low -> exactly one word.
    p0 = pops_a;
    q_a.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 99);
    drive(1'b0, 1'b0);
    tick_n(20 * BIT);
    check("break_one_word", pops_a - p0, 1);
    check("break_busy", ifa.busy, 0);
    drive(1'b0, 1'b1);
    tick_n(2 * BIT);
    check("break_no_extra", pops_a - p0, 1);
    q_a.push_back({2'b00, 8'h11});
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 99);
    drive(1'b0, 1'b1);
    tick_n(BIT);
    wait_drain("break_recover");

    // Glitch: 8 clocks low is a false start.
    p0 = pops_a;
    drive(1'b0, 1'b0);
    tick_n(8);
    drive(1'b0, 1'b1);
    check("glitch_busy_hi", ifa.busy, 1);
    tick_n(BIT - 8);
    check("glitch_busy_lo", ifa.busy, 0);
    check("glitch_no_push", pops_a - p0 + ifa.rx_valid, 0);

    // Overrun: consumer stalled, five back-to-back frames into a 4-deep FIFO.
    ifa.rx_ready = 1'b0;
    o0 = ovr_a;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_a.push_back({2'b00, 8'(k)});
      send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1, 99);
      if (k == 4) check("ovr_before_5th", ovr_a - o0, 0);
    end
    drive(1'b0, 1'b1);
    tick_n(BIT);
    check("ovr_count", ovr_a - o0, 1);
    check("full_valid", ifa.rx_valid, 1);
    check("full_head", ifa.rx_data, 8'h01);
    ifa.rx_ready = 1'b1;
    wait_drain("ovr_drain");
    tick_n(2);
    check("empty_valid", ifa.rx_valid, 0);
    check("empty_hold_data", ifa.rx_data, 8'h04);

    // Reset in the middle of the data bits of 0x55.
    p0 = pops_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 5);
    rst_n = 1'b0;
    drive(1'b0, 1'b1);
    tick_n(10);
    check("midrst_state", {ifa.rx_valid, ifa.busy}, 0);
    rst_n = 1'b1;
    tick_n(2 * BIT);
    check("midrst_no_push", pops_a - p0 + ifa.rx_valid, 0);
    q_a.push_back({2'b00, 8'h77});
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 99);
    drive(1'b0, 1'b1);
    tick_n(BIT);
    wait_drain("midrst_recover");
    check("ovr_p_none", ovr_p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
